// File: rtl/mux32_sched_pkg.sv
// rtl/mux32_sched_pkg.sv - shared types and defaults for the mux32 round-robin scheduler
//
// Purpose: FSM state type, default sizing constants and a beat-width helper
//          used by mux32_rr_scheduler and rr_pick.
// Ports:   none (package).

package mux32_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } sched_state_t;

  localparam int N_REQ_DEF     = 32;
  localparam int MAX_BURST_DEF = 4;

  // Width needed to count 0..max_burst accepted beats.
  function automatic int beat_width(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker for the mux32 scheduler
//
// Purpose: returns the first requester after last_ptr (cyclically) with req set.
// Ports:
//   req       in   N_REQ   request vector
//   last_ptr  in   SEL_W   index of the most recent owner; search starts after it
//   any       out  1       at least one request is present
//   idx       out  SEL_W   chosen requester (meaningful only when any=1)

module rr_pick
  import mux32_sched_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int SEL_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] last_ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic [N_REQ-1:0] rot;
  logic [SEL_W-1:0] src;
  int               start;
  int               pos;
  int               enc;
  int               unrot;

  always_comb begin
    rot   = '0;
    src   = '0;
    pos   = 0;
    enc   = 0;
    unrot = 0;

    // Search origin is last_ptr+1, wrapping past the top requester to 0.
    start = (int'(last_ptr) >= N_REQ - 1) ? 0 : int'(last_ptr) + 1;

    // Rotate so the search origin lands at bit 0.
    for (int i = 0; i < N_REQ; i++) begin
      pos = i + start;
      if (pos >= N_REQ) pos = pos - N_REQ;
      src    = SEL_W'(pos);
      rot[i] = req[src];
    end

    // Lowest set bit of the rotated vector wins.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) enc = i;
    end

    // Undo the rotation to get the real requester index.
    unrot = enc + start;
    if (unrot >= N_REQ) unrot = unrot - N_REQ;

    idx = SEL_W'(unrot);
    any = |req;
  end

endmodule

// File: rtl/mux32_rr_scheduler.sv
// rtl/mux32_rr_scheduler.sv - round-robin burst scheduler driving a shared mux32 select
//
// Purpose: grants one requester at a time, drives mux32.select, and holds the
//          grant for up to MAX_BURST accepted beats or until the owner withdraws.
// Ports:
//   clk     in   1        clock, rising edge
//   rst     in   1        asynchronous active-low reset
//   req     in   N_REQ    per-requester data-present flags
//   ready   in   1        consumer accepts the current beat
//   select  out  SEL_W    registered mux32 select
//   grant   out  N_REQ    registered one-hot owner, zero when idle
//   busy    out  1        a grant is held
//   valid   out  1        busy & req[select], combinational
//   beat    out  BEAT_W   beats accepted in the current grant

module mux32_rr_scheduler
  import mux32_sched_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEF,
  parameter int SEL_W     = $clog2(N_REQ),
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int BEAT_W    = beat_width(MAX_BURST)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req,
  input  logic              ready,
  output logic [SEL_W-1:0]  select,
  output logic [N_REQ-1:0]  grant,
  output logic              busy,
  output logic              valid,
  output logic [BEAT_W-1:0] beat
);

  sched_state_t     state;
  logic [SEL_W-1:0] last_ptr;
  logic [SEL_W-1:0] pick_ptr;
  logic [SEL_W-1:0] pick_idx;
  logic [N_REQ-1:0] pick_onehot;
  logic             pick_any;
  logic             accept;
  logic             last_beat;
  logic             release_now;

  assign busy   = (state == BUSY);
  assign valid  = busy & req[select];
  assign accept = valid & ready;

  assign last_beat = (beat == BEAT_W'(MAX_BURST - 1));

  // Release on the final beat of a burst, or when the owner drops its request
  // (in which case valid is low and no beat is taken this cycle).
  assign release_now = busy & ((accept & last_beat) | ~req[select]);

  // While busy, a release re-picks from the current owner, which is exactly the
  // pointer value last_ptr is about to take.
  assign pick_ptr    = busy ? select : last_ptr;
  assign pick_onehot = N_REQ'(1) << pick_idx;

  rr_pick #(
    .N_REQ (N_REQ),
    .SEL_W (SEL_W)
  ) u_pick (
    .req      (req),
    .last_ptr (pick_ptr),
    .any      (pick_any),
    .idx      (pick_idx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      select   <= '0;
      grant    <= '0;
      beat     <= '0;
      last_ptr <= SEL_W'(N_REQ - 1);
    end else if (state == IDLE) begin
      if (pick_any) begin
        state  <= BUSY;
        select <= pick_idx;
        grant  <= pick_onehot;
        beat   <= '0;
      end
    end else if (release_now) begin
      last_ptr <= select;
      beat     <= '0;
      // Any remaining request (including the owner's own on a full burst)
      // means a back-to-back grant; otherwise fall idle with select held.
      if (pick_any) begin
        select <= pick_idx;
        grant  <= pick_onehot;
      end else begin
        state <= IDLE;
        grant <= '0;
      end
    end else if (accept) begin
      beat <= beat + BEAT_W'(1);
    end
  end

endmodule

// File: tb/tb_mux32_rr_scheduler.sv
// tb/tb_mux32_rr_scheduler.sv - directed self-checking bench for mux32_rr_scheduler

module tb_mux32_rr_scheduler;

  logic        clk   = 1'b0;
  logic        rst   = 1'b0;
  logic        ready = 1'b0;
  logic [31:0] req   = '0;
  logic [4:0]  select;
  logic [31:0] grant;
  logic        busy;
  logic        valid;
  logic [2:0]  beat;

  int n_cmp = 0;
  int n_err = 0;

  mux32_rr_scheduler #(
    .N_REQ     (32),
    .MAX_BURST (4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .ready  (ready),
    .select (select),
    .grant  (grant),
    .busy   (busy),
    .valid  (valid),
    .beat   (beat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_owner(input string tag, input int owner, input int b);
    chk({tag, "_grant"},  grant,        32'd1 << owner);
    chk({tag, "_select"}, 32'(select),  32'(owner));
    chk({tag, "_beat"},   32'(beat),    32'(b));
    chk({tag, "_busy"},   32'(busy),    32'd1);
  endtask

  task automatic expect_idle(input string tag, input int sel);
    chk({tag, "_grant"},  grant,       32'd0);
    chk({tag, "_select"}, 32'(select), 32'(sel));
    chk({tag, "_busy"},   32'(busy),   32'd0);
    chk({tag, "_valid"},  32'(valid),  32'd0);
  endtask

  // Per-cycle invariants, sampled mid-cycle away from both clock edges.
  always @(posedge clk) begin
    #3;
    if (rst) begin
      chk("inv_onehot0", 32'($onehot0(grant)), 32'd1);
      chk("inv_grant", grant, busy ? (32'd1 << select) : 32'd0);
      chk("inv_beat_lt_max", 32'(beat < 3'd4), 32'd1);
      chk("inv_valid", 32'(valid), 32'(busy & req[select]));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // 1: reset holds everything low even with all requests asserted
    rst = 1'b0; req = '1; ready = 1'b0;
    #12;
    chk("t1_rst_busy",   32'(busy),   32'd0);
    chk("t1_rst_grant",  grant,       32'd0);
    chk("t1_rst_select", 32'(select), 32'd0);
    chk("t1_rst_valid",  32'(valid),  32'd0);
    chk("t1_rst_beat",   32'(beat),   32'd0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); expect_owner("t1_first", 0, 0);
    rst = 1'b0; #1;
    expect_idle("t1_rst2", 0);
    req = '0;
    @(negedge clk); rst = 1'b1;

    // 2: lone requester 7 re-wins after 4 beats with no idle gap
    @(negedge clk); req = 32'd1 << 7; ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); expect_owner($sformatf("t2_k%0d", k), 7, k % 4);
    end
    req = '0;
    @(negedge clk); expect_idle("t2_idle", 7);

    // 3: requesters 3 and 31 alternate, wrapping from 31 back to 3
    rst = 1'b0; #1; rst = 1'b1;
    req = (32'd1 << 3) | (32'd1 << 31); ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      expect_owner($sformatf("t3_k%0d", k), ((k / 4) % 2 == 1) ? 31 : 3, k % 4);
    end
    req = '0;
    @(negedge clk); expect_idle("t3_idle", 31);

    // 4: owner withdraws mid-burst, first with nobody pending, then with 12 pending
    req = 32'd1 << 5; ready = 1'b1;
    @(negedge clk); expect_owner("t4a", 5, 0);
    @(negedge clk); expect_owner("t4b", 5, 1);
    ready = 1'b0; req = '0;
    @(negedge clk); expect_idle("t4_idle", 5);
    req = 32'd1 << 5; ready = 1'b1;
    @(negedge clk); expect_owner("t4c", 5, 0);
    @(negedge clk); expect_owner("t4d", 5, 1);
    req = 32'd1 << 12; ready = 1'b0;
    @(negedge clk); expect_owner("t4_next", 12, 0);
    req = '0;
    @(negedge clk); expect_idle("t4_idle2", 12);

    // 5: backpressure holds owner 2 at beat 0; 9 arrives and wins after the burst
    req = 32'd1 << 2; ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      expect_owner($sformatf("t5_hold%0d", c), 2, 0);
      chk($sformatf("t5_valid%0d", c), 32'(valid), 32'd1);
      if (c == 5) req = (32'd1 << 2) | (32'd1 << 9);
    end
    ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      @(negedge clk); expect_owner($sformatf("t5_beat%0d", k), 2, k);
    end
    @(negedge clk); expect_owner("t5_release", 9, 0);
    req = '0; ready = 1'b0;
    @(negedge clk); expect_idle("t5_idle", 9);
    // ready with nothing valid changes nothing
    ready = 1'b1;
    @(negedge clk); expect_idle("t5_ready_idle", 9);
    chk("t5_ready_idle_beat", 32'(beat), 32'd0);

    // 6: asynchronous reset at beat 2 of owner 9; first grant afterwards is 0
    req = 32'd1 << 9; ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); expect_owner($sformatf("t6_k%0d", k), 9, k);
    end
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_busy",   32'(busy),   32'd0);
    chk("t6_rst_grant",  grant,       32'd0);
    chk("t6_rst_select", 32'(select), 32'd0);
    chk("t6_rst_beat",   32'(beat),   32'd0);
    chk("t6_rst_valid",  32'(valid),  32'd0);
    req = (32'd1 << 9) | 32'd1;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); expect_owner("t6_first", 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
